// File: rtl/fl_binder_pkg.sv
// rtl/fl_binder_pkg.sv - shared types and helpers for the FrameLink ticket binder
package fl_binder_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    TRANSFER = 1'b1
  } state_e;

  // Ceiling log2; clog2(1) = 0. Usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

  // Source-index width for the default four-input configuration.
  localparam int SEL_WIDTH = clog2(4);

endpackage

// File: rtl/fl_binder_ticket_fifo.sv
// rtl/fl_binder_ticket_fifo.sv - synchronous ticket FIFO with a registered head word
module fl_binder_ticket_fifo
  import fl_binder_pkg::*;
#(
  parameter int WIDTH = SEL_WIDTH + 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             vld_q, vld_d;
  logic             push, pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next-state: head is precomputed from the post-write memory so it is valid the cycle after a push.
  always_comb begin
    push     = wr_en && (count_q != CNT_W'(DEPTH));
    pop      = rd_en && vld_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
    end
    wr_ptr_d = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    head_d   = mem_d[rd_ptr_d];
    vld_d    = (count_d != '0);
  end

  // Storage array carries no reset; only control state does.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control state and registered head.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      vld_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      vld_q    <= vld_d;
    end
  end

  assign rd_data = head_q;
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = !vld_q;

endmodule

// File: rtl/fl_ticket_binder_nfifo2fifo.sv
// rtl/fl_ticket_binder_nfifo2fifo.sv - round-robin FrameLink merger with source-tagged ticket FIFO
module fl_ticket_binder_nfifo2fifo
  import fl_binder_pkg::*;
#(
  parameter int DATA_WIDTH        = 64,
  parameter int DREM_WIDTH        = clog2(DATA_WIDTH / 8),
  parameter int OUTPUT_COUNT      = 4,
  parameter int TICKET_WIDTH      = 16,
  parameter int TICKET_FIFO_ITEMS = 8
) (
  input  logic                                         CLK,
  input  logic                                         RESET,
  input  logic [OUTPUT_COUNT*DATA_WIDTH-1:0]           RX_DATA,
  input  logic [OUTPUT_COUNT*DREM_WIDTH-1:0]           RX_REM,
  input  logic [OUTPUT_COUNT-1:0]                      RX_SOF_N,
  input  logic [OUTPUT_COUNT-1:0]                      RX_EOF_N,
  input  logic [OUTPUT_COUNT-1:0]                      RX_SOP_N,
  input  logic [OUTPUT_COUNT-1:0]                      RX_EOP_N,
  input  logic [OUTPUT_COUNT-1:0]                      RX_SRC_RDY_N,
  output logic [OUTPUT_COUNT-1:0]                      RX_DST_RDY_N,
  input  logic [OUTPUT_COUNT*TICKET_WIDTH-1:0]         CTRL_DATA_IN,
  input  logic [OUTPUT_COUNT-1:0]                      CTRL_DATA_IN_VLD,
  output logic [OUTPUT_COUNT-1:0]                      CTRL_DATA_IN_RQ,
  output logic [DATA_WIDTH-1:0]                        TX_DATA,
  output logic [DREM_WIDTH-1:0]                        TX_REM,
  output logic                                         TX_SOF_N,
  output logic                                         TX_EOF_N,
  output logic                                         TX_SOP_N,
  output logic                                         TX_EOP_N,
  output logic                                         TX_SRC_RDY_N,
  input  logic                                         TX_DST_RDY_N,
  output logic [clog2(OUTPUT_COUNT)+TICKET_WIDTH-1:0]  CTRL_DATA_OUT,
  output logic                                         CTRL_DATA_OUT_VLD,
  input  logic                                         CTRL_DATA_OUT_RQ
);

  localparam int SEL_W  = clog2(OUTPUT_COUNT);
  localparam int FIFO_W = SEL_W + TICKET_WIDTH;

  state_e                  state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [SEL_W-1:0]        last_q, last_d;
  logic [OUTPUT_COUNT-1:0] cand;
  logic [SEL_W-1:0]        cand_idx;
  logic                    grant_hit;
  logic [SEL_W-1:0]        grant_idx;
  logic                    in_transfer;
  logic                    word_xfer, sof_xfer, eof_xfer;
  logic                    fifo_full, fifo_empty;
  logic [FIFO_W-1:0]       fifo_wr_data;

  // An input may start a frame only with SOF, a valid ticket and room for that ticket.
  always_comb begin
    cand = '0;
    for (int i = 0; i < OUTPUT_COUNT; i++) begin
      cand[i] = !RX_SRC_RDY_N[i] && !RX_SOF_N[i] && CTRL_DATA_IN_VLD[i] && !fifo_full;
    end
  end

  // Round-robin search starting one past the last winner; the index wraps by truncation.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = last_q;
    cand_idx  = '0;
    for (int k = 1; k <= OUTPUT_COUNT; k++) begin
      cand_idx = last_q + SEL_W'(k);
      if (!grant_hit && cand[cand_idx]) begin
        grant_hit = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  // Zero-latency output mux and handshake steering for the selected input.
  always_comb begin
    in_transfer  = (state_q == TRANSFER);
    TX_DATA      = RX_DATA[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
    TX_REM       = RX_REM[int'(sel_q)*DREM_WIDTH +: DREM_WIDTH];
    TX_SOF_N     = 1'b1;
    TX_EOF_N     = 1'b1;
    TX_SOP_N     = 1'b1;
    TX_EOP_N     = 1'b1;
    TX_SRC_RDY_N = 1'b1;
    RX_DST_RDY_N = '1;
    if (in_transfer) begin
      TX_SOF_N            = RX_SOF_N[sel_q];
      TX_EOF_N            = RX_EOF_N[sel_q];
      TX_SOP_N            = RX_SOP_N[sel_q];
      TX_EOP_N            = RX_EOP_N[sel_q];
      TX_SRC_RDY_N        = RX_SRC_RDY_N[sel_q];
      RX_DST_RDY_N[sel_q] = TX_DST_RDY_N;
    end
    word_xfer       = in_transfer && !RX_SRC_RDY_N[sel_q] && !TX_DST_RDY_N;
    sof_xfer        = word_xfer && !RX_SOF_N[sel_q];
    eof_xfer        = word_xfer && !RX_EOF_N[sel_q];
    CTRL_DATA_IN_RQ = '0;
    if (sof_xfer) begin
      CTRL_DATA_IN_RQ[sel_q] = 1'b1;
    end
    fifo_wr_data = {sel_q, CTRL_DATA_IN[int'(sel_q)*TICKET_WIDTH +: TICKET_WIDTH]};
  end

  // FSM next state: grant from IDLE, return to IDLE on the EOF word.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (grant_hit) begin
          state_d = TRANSFER;
          sel_d   = grant_idx;
          last_d  = grant_idx;
        end
      end
      TRANSFER: begin
        if (eof_xfer) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state; last resets to the top index so input 0 wins first.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= SEL_W'(OUTPUT_COUNT - 1);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  fl_binder_ticket_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (TICKET_FIFO_ITEMS)
  ) u_ticket_fifo (
    .clk     (CLK),
    .reset   (RESET),
    .wr_en   (sof_xfer),
    .wr_data (fifo_wr_data),
    .rd_en   (CTRL_DATA_OUT_RQ),
    .rd_data (CTRL_DATA_OUT),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign CTRL_DATA_OUT_VLD = !fifo_empty;

endmodule
